// File: rtl/stim_playback_sequencer_pkg.sv
// Shared types for the stimulus playback sequencer.
//   stim_entry_t : one table entry (data word + pre-issue idle delay), default widths
//   seq_state_e  : playback FSM states
//   CNT_W        : width of the issued/stall bookkeeping counters
package stim_playback_sequencer_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DLY_W  = 8;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DLY_W-1:0]  dly;
  } stim_entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StGap,
    StDrive,
    StDone
  } seq_state_e;

endpackage

// File: rtl/stim_playback_sequencer_table_ram.sv
// Simple dual-port synchronous RAM holding the stimulus table.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : write word
//   rd_en   : read strobe; rd_data updates one cycle later, holds otherwise
//   rd_addr : read index
//   rd_data : registered read word
module stim_table_ram #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/stim_playback_sequencer.sv
// Replays a table of stimulus entries (data + idle delay) onto a valid/ready stream,
// optionally looping, with issued/stall bookkeeping counters.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en/addr/data/dly: table write port, honoured only when not busy
//   num_entries        : entries per pass, clamped to DEPTH, latched at start
//   loop_en            : restart from entry 0 after the last entry (sampled per pass end)
//   start, stop        : playback control pulses
//   out_valid/data/ready: output stream
//   busy, done         : playback in progress / sticky completion flag
//   issued_cnt, stall_cnt: handshakes and stalled cycles since last start
module stim_playback_sequencer
  import stim_playback_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DLY_W  = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DLY_W-1:0]  wr_dly,
  input  logic [ADDR_W:0]   num_entries,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W:0] DepthN = (ADDR_W+1)'(DEPTH);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [DLY_W-1:0]    gap_q, gap_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                done_q, done_d;
  logic                stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic [ADDR_W:0]     n_clamped;
  logic                last_entry;
  logic                rd_en;
  logic [DATA_W+DLY_W-1:0] rd_entry;
  logic [DATA_W-1:0]   rd_data;
  logic [DLY_W-1:0]    rd_dly;

  assign busy = (state_q == StFetch) || (state_q == StGap) || (state_q == StDrive);

  assign n_clamped  = (num_entries > DepthN) ? DepthN : num_entries;
  assign last_entry = ({1'b0, idx_q} == (n_q - (ADDR_W+1)'(1)));

  // Read is launched on the edge that enters FETCH so the entry is already
  // available during FETCH; this keeps start->valid at two cycles.
  assign rd_en   = (state_d == StFetch);
  assign rd_data = rd_entry[DATA_W+DLY_W-1:DLY_W];
  assign rd_dly  = rd_entry[DLY_W-1:0];

  stim_table_ram #(
    .WIDTH  (DATA_W + DLY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data ({wr_data, wr_dly}),
    .rd_en   (rd_en),
    .rd_addr (idx_d),
    .rd_data (rd_entry)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    gap_d       = gap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    stop_pend_d = stop_pend_q;
    issued_d    = issued_q;
    stall_d     = stall_q;

    unique case (state_q)
      StIdle, StDone: begin
        // start takes priority over a coincident stop here
        if (start) begin
          idx_d       = '0;
          n_d         = n_clamped;
          issued_d    = '0;
          stall_d     = '0;
          stop_pend_d = 1'b0;
          if (n_clamped == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
            done_d  = 1'b0;
          end
        end
      end

      StFetch: begin
        if (stop) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          out_data_d = rd_data;
          if (rd_dly == '0) begin
            state_d     = StDrive;
            out_valid_d = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = rd_dly;
          end
        end
      end

      StGap: begin
        if (stop) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (gap_q == DLY_W'(1)) begin
          state_d     = StDrive;
          out_valid_d = 1'b1;
        end else begin
          gap_d = gap_q - DLY_W'(1);
        end
      end

      StDrive: begin
        if (out_ready) begin
          issued_d    = issued_q + CNT_W'(1);
          out_valid_d = 1'b0;
          if (stop || stop_pend_q) begin
            state_d     = StDone;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (!last_entry) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StFetch;
          end else if (loop_en) begin
            idx_d   = '0;
            state_d = StFetch;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          stall_d = stall_q + CNT_W'(1);
          // valid is never withdrawn; remember the abort until the handshake
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      n_q         <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      issued_q    <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      issued_q    <= issued_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_stim_playback_sequencer.sv
// Self-checking bench: inputs change and outputs are sampled on the falling edge.
// The reference model predicts, per issued entry, the cycle valid must first appear
// (previous handshake + 2 + delay) and the data, from a shadow copy of the table.
module tb_stim_playback_sequencer;
  import stim_playback_sequencer_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DLY_W  = 8;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DLY_W-1:0]  wr_dly = '0;
  logic [ADDR_W:0]   num_entries = '0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [31:0]       issued_cnt;
  logic [31:0]       stall_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  stim_entry_t model_tbl [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stim_playback_sequencer #(
    .DATA_W (DATA_W),
    .DLY_W  (DLY_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_dly      (wr_dly),
    .num_entries (num_entries),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt),
    .stall_cnt   (stall_cnt)
  );

  // All tasks are entered and left on a falling edge.
  task automatic load(input int addr, input logic [31:0] data, input logic [7:0] dly);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data;
    wr_dly  = dly;
    model_tbl[addr] = '{data: data, dly: dly};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n, input bit lp, input bit with_stop, output int t0);
    num_entries = n[ADDR_W:0];
    loop_en     = lp;
    start       = 1'b1;
    stop        = with_stop;
    t0          = cyc;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s wait_valid: out_valid=%0b after %0d cycles, required 1", name, out_valid, w);
    end
  endtask

  // Plays one started pass to completion with randomized ready and checks every issue.
  task automatic run_pass(input string name, input int n, input int total, input int ready_pct,
                          input int first_stall, input int clear_at, input bit busy_writes,
                          input int t0);
    int k = 0;
    int exp_at;
    int stalls = 0;
    int fs = first_stall;
    int budget;
    bit v;
    bit rdy;
    logic [31:0] exp_d;
    exp_at = t0 + 2 + int'(model_tbl[0].dly);
    budget = cyc + 64 + total * 300 + first_stall;
    while (k < total && cyc < budget) begin
      v     = out_valid;
      exp_d = model_tbl[k % n].data;
      if (v && cyc < exp_at) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s early_valid issue %0d: valid at cycle %0d, required not before %0d",
                 name, k, cyc, exp_at);
        break;
      end else if (cyc >= exp_at) begin
        n_cmp++;
        if (v !== 1'b1 || out_data !== exp_d) begin
          n_err++;
          $display("FAIL %s issue %0d: valid=%0b data=%h at cycle %0d, required valid=1 data=%h",
                   name, k, v, out_data, cyc, exp_d);
          break;
        end
      end
      if (k == 0 && fs > 0 && v) begin
        rdy = 1'b0;
        fs--;
      end else begin
        rdy = ($urandom_range(0, 99) < ready_pct);
      end
      out_ready = rdy;
      if (busy_writes) begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'($urandom_range(0, n - 1));
        wr_data = $urandom;
        wr_dly  = DLY_W'($urandom_range(0, 255));
      end
      if (v && !rdy) stalls++;
      if (v && rdy) begin
        k++;
        if (k < total) exp_at = cyc + 2 + int'(model_tbl[k % n].dly);
        if (k == clear_at) loop_en = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    wr_en     = 1'b0;
    if (k < total) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s progress: %0d issues seen, required %0d", name, k, total);
    end
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || issued_cnt !== 32'(total) ||
        stall_cnt !== 32'(stalls)) begin
      n_err++;
      $display("FAIL %s end: done=%0b valid=%0b busy=%0b issued=%0d stall=%0d, required 1 0 0 %0d %0d",
               name, done, out_valid, busy, issued_cnt, stall_cnt, total, stalls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        issued_cnt !== '0 || stall_cnt !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%0b data=%h busy=%0b done=%0b issued=%0d stall=%0d, required all 0",
               out_valid, out_data, busy, done, issued_cnt, stall_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%0b done=%0b valid=%0b, required 0 0 0", busy, done, out_valid);
    end
  endtask

  task automatic test_zero_entries();
    int t0;
    bit seen = 1'b0;
    do_start(0, 1'b0, 1'b0, t0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: done=%0b busy=%0b, required 1 0", done, busy);
    end
    repeat (6) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL zero_valid: out_valid seen=1, required 0");
    end
  endtask

  task automatic test_basic();
    int t0;
    load(0, 32'hA1, 8'd0);
    load(1, 32'hB2, 8'd2);
    load(2, 32'hC3, 8'd0);
    do_start(3, 1'b0, 1'b0, t0);
    run_pass("basic", 3, 3, 100, 0, 0, 1'b0, t0);
    n_cmp++;
    if (cyc - t0 !== 9) begin
      n_err++;
      $display("FAIL basic_done_time: done seen at start+%0d, required start+9", cyc - t0);
    end
  endtask

  task automatic test_stall();
    int t0;
    do_start(3, 1'b0, 1'b0, t0);
    run_pass("stall", 3, 3, 100, 5, 0, 1'b0, t0);
    n_cmp++;
    if (stall_cnt !== 32'd5) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d, required 5", stall_cnt);
    end
  endtask

  task automatic test_loop();
    int t0;
    load(0, 32'h11, 8'd0);
    load(1, 32'h22, 8'd0);
    do_start(2, 1'b1, 1'b0, t0);
    run_pass("loop", 2, 6, 100, 0, 5, 1'b0, t0);
  endtask

  task automatic test_stop_gap();
    int t0;
    bit seen = 1'b0;
    load(0, 32'h5A, 8'd10);
    do_start(1, 1'b0, 1'b0, t0);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_gap: done=%0b busy=%0b valid=%0b, required 1 0 0", done, busy, out_valid);
    end
    repeat (12) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen || issued_cnt !== '0) begin
      n_err++;
      $display("FAIL stop_gap_quiet: valid seen=%0b issued=%0d, required 0 0", seen, issued_cnt);
    end
  endtask

  task automatic test_stop_drive();
    int t0;
    load(0, 32'h77, 8'd0);
    load(1, 32'h88, 8'd1);
    do_start(2, 1'b1, 1'b0, t0);
    out_ready = 1'b0;
    wait_valid("stop_drive");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h77 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL stop_drive_hold: valid=%0b data=%h busy=%0b, required 1 00000077 1",
                 out_valid, out_data, busy);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || issued_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL stop_drive_end: done=%0b valid=%0b busy=%0b issued=%0d, required 1 0 0 1",
               done, out_valid, busy, issued_cnt);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_clamp();
    int t0;
    for (int i = 0; i < int'(DEPTH); i++) load(i, $urandom, 8'd0);
    do_start(300, 1'b0, 1'b0, t0);
    run_pass("clamp", 256, 256, 100, 0, 0, 1'b0, t0);
  endtask

  task automatic test_wr_busy();
    int t0;
    for (int i = 0; i < 4; i++) load(i, $urandom, 8'($urandom_range(0, 3)));
    do_start(4, 1'b0, 1'b0, t0);
    run_pass("wr_busy_1", 4, 4, 80, 0, 0, 1'b1, t0);
    do_start(4, 1'b0, 1'b0, t0);
    run_pass("wr_busy_2", 4, 4, 80, 0, 0, 1'b0, t0);
  endtask

  task automatic test_random();
    int t0;
    int n;
    int c;
    int total;
    bit lp;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) load(i, $urandom, 8'($urandom_range(0, 3)));
      lp = 1'($urandom_range(0, 1));
      if (lp) begin
        c     = $urandom_range(1, 2 * n + 1);
        total = ((c + n - 1) / n) * n;
      end else begin
        c     = 0;
        total = n;
      end
      do_start(n, lp, 1'b0, t0);
      run_pass("random", n, total, 60, 0, c, 1'b0, t0);
    end
  endtask

  task automatic test_rst_drive();
    int t0;
    load(0, 32'h31, 8'd0);
    load(1, 32'h32, 8'd1);
    load(2, 32'h33, 8'd0);
    do_start(3, 1'b0, 1'b0, t0);
    out_ready = 1'b0;
    wait_valid("rst_drive");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        issued_cnt !== '0 || stall_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_drive: valid=%0b data=%h busy=%0b done=%0b issued=%0d stall=%0d, required all 0",
               out_valid, out_data, busy, done, issued_cnt, stall_cnt);
    end
    // stop coincident with start from IDLE must not abort the new pass
    do_start(3, 1'b0, 1'b1, t0);
    run_pass("rst_replay", 3, 3, 80, 0, 0, 1'b0, t0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_entries();
    test_basic();
    test_stall();
    test_loop();
    test_stop_gap();
    test_stop_drive();
    test_wr_busy();
    test_random();
    test_clamp();
    test_rst_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
